// File: rtl/shift_issue_unit.sv
// shift_issue_unit: FIFO-buffered issue stage that turns an external rotator into rotates and logical/arithmetic shifts
module shift_issue_unit #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_data,
    input  logic [4:0]               in_amt,
    input  logic [2:0]               in_op,
    output logic [31:0]              rot_a,
    output logic [4:0]               rot_shift,
    output logic                     rot_l,
    input  logic [31:0]              rot_b,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_data,
    output logic                     out_err,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [2:0] OP_ROL = 3'b000;
    localparam logic [2:0] OP_ROR = 3'b001;
    localparam logic [2:0] OP_SLL = 3'b010;
    localparam logic [2:0] OP_SRL = 3'b011;
    localparam logic [2:0] OP_SRA = 3'b111;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  amt;
        logic [2:0]  op;
    } req_t;

    req_t            mem_q [DEPTH];
    req_t            head;
    logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            out_valid_q, out_valid_d, out_err_q, out_err_d;
    logic [31:0]     out_data_q, out_data_d;
    logic            head_valid, push, pop, err;
    logic [31:0]     lmask, rmask, srl, res;

    always_comb begin
        head        = mem_q[rd_q];
        head_valid  = cnt_q != '0;
        in_ready    = cnt_q != CW'(DEPTH);
        push        = in_valid && in_ready;
        pop         = head_valid && (!out_valid_q || out_ready);
        wr_d        = push ? wr_q + AW'(1) : wr_q;
        rd_d        = pop ? rd_q + AW'(1) : rd_q;
        cnt_d       = cnt_q + CW'(push) - CW'(pop);
        lmask       = 32'hFFFF_FFFF << head.amt;
        rmask       = 32'hFFFF_FFFF >> head.amt;
        srl         = rot_b & rmask;
        err         = !(head.op inside {OP_ROL, OP_ROR, OP_SLL, OP_SRL, OP_SRA});
        res         = (head.op == OP_ROL || head.op == OP_ROR) ? rot_b :
                      (head.op == OP_SLL) ? rot_b & lmask :
                      (head.op == OP_SRL) ? srl :
                      (head.op == OP_SRA) ? srl | (head.data[31] ? ~rmask : 32'h0) :
                      head.data;
        rot_a       = head_valid ? head.data : 32'h0;
        rot_shift   = head_valid ? head.amt : 5'h0;
        rot_l       = head_valid && (head.op == OP_ROL || head.op == OP_SLL);
        out_valid_d = pop || (out_valid_q && !out_ready);
        out_data_d  = pop ? res : out_data_q;
        out_err_d   = pop ? err : out_err_q;
    end

    // Storage is deliberately left unreset; occupancy is tracked by cnt_q alone.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {in_data, in_amt, in_op};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 32'h0;
            out_err_q   <= 1'b0;
        end else begin
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_err    = out_err_q;
    assign fifo_count = cnt_q;
endmodule

// File: tb/tb_shift_issue_unit.sv
// tb_shift_issue_unit: directed vectors with a scoreboard queue drained by an output monitor
module tb_shift_issue_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [4:0]  in_amt = '0;
    logic [2:0]  in_op = '0;
    logic [31:0] rot_a;
    logic [4:0]  rot_shift;
    logic        rot_l;
    logic [31:0] rot_b;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_err;
    logic [2:0]  fifo_count;

    logic [32:0] sb [$];
    int nvec = 0;
    int nerr = 0;
    int nout = 0;

    shift_issue_unit #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_amt(in_amt), .in_op(in_op),
        .rot_a(rot_a), .rot_shift(rot_shift), .rot_l(rot_l), .rot_b(rot_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_err(out_err), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // External rotator
    logic [63:0] rl, rr;
    assign rl    = {rot_a, rot_a} << rot_shift;
    assign rr    = {rot_a, rot_a} >> rot_shift;
    assign rot_b = rot_l ? rl[63:32] : rr[31:0];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) chk("unexpected_output", {31'h0, out_err, out_data}, 64'hDEAD);
            else chk("result", {31'h0, out_err, out_data}, {31'h0, sb.pop_front()});
            nout++;
        end
    end

    task automatic send(input logic [31:0] d, input logic [4:0] a, input logic [2:0] o,
                        input logic [31:0] e, input logic err);
        logic r;
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data = d;
        in_amt = a;
        in_op = o;
        for (int i = 0; i < 50 && !ok; i++) begin
            r = in_ready;
            @(posedge clk);
            if (r) begin
                ok = 1'b1;
                sb.push_back({err, e});
            end
            #1;
        end
        in_valid = 1'b0;
        if (!ok) chk("send_timeout", 64'h0, 64'h1);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain", 64'(sb.size()), 64'h0);
    endtask

    initial begin
        int acc;
        int n0;
        logic [31:0] k;
        logic r;
        logic [2:0] ops [8];
        ops = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b111, 3'b100, 3'b101, 3'b110};
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_out_data", 64'(out_data), 64'h0);
        chk("rst_out_err", 64'(out_err), 64'h0);
        chk("rst_rot", {rot_a, 26'h0, rot_shift, rot_l}, 64'h0);
        chk("rst_in_ready", 64'(in_ready), 64'h1);
        chk("rst_count", 64'(fifo_count), 64'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        send(32'h8000_0001, 5'd1, 3'b000, 32'h0000_0003, 1'b0);
        chk("lat_t1_out_valid", 64'(out_valid), 64'h0);
        chk("lat_t1_count", 64'(fifo_count), 64'h1);
        chk("lat_rot_a", 64'(rot_a), 64'h8000_0001);
        chk("lat_rot_sh_l", {rot_shift, rot_l}, {5'd1, 1'b1});
        @(posedge clk);
        #1;
        chk("lat_t2_out_valid", 64'(out_valid), 64'h1);
        chk("lat_t2_out_data", 64'(out_data), 64'h3);
        drain();
        send(32'h0000_0001, 5'd4, 3'b001, 32'h1000_0000, 1'b0);
        chk("ror_rot_l", 64'(rot_l), 64'h0);
        send(32'hFFFF_FFFF, 5'd8, 3'b010, 32'hFFFF_FF00, 1'b0);
        send(32'h8000_0000, 5'd31, 3'b011, 32'h0000_0001, 1'b0);
        send(32'h8000_0000, 5'd31, 3'b111, 32'hFFFF_FFFF, 1'b0);
        send(32'h4000_0000, 5'd4, 3'b111, 32'h0400_0000, 1'b0);
        send(32'h1234_5678, 5'd7, 3'b100, 32'h1234_5678, 1'b1);
        send(32'h0000_00F0, 5'd4, 3'b011, 32'h0000_000F, 1'b0);
        for (int i = 0; i < 8; i++)
            send(32'h9ABC_DEF0 ^ 32'(i), 5'd0, ops[i], 32'h9ABC_DEF0 ^ 32'(i), i >= 5);
        drain();

        out_ready = 1'b0;
        k = 32'd1;
        acc = 0;
        in_valid = 1'b1;
        in_amt = 5'd0;
        in_op = 3'b000;
        for (int c = 0; c < 10; c++) begin
            in_data = k;
            r = in_ready;
            @(posedge clk);
            if (r) begin
                sb.push_back({1'b0, k});
                k++;
                acc++;
            end
            #1;
        end
        in_valid = 1'b0;
        chk("bp_accepted", 64'(acc), 64'd5);
        chk("bp_in_ready", 64'(in_ready), 64'h0);
        chk("bp_count", 64'(fifo_count), 64'd4);
        chk("bp_stall_out", {31'h0, out_valid, out_data}, {31'h0, 1'b1, 32'h1});
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_in_ready_back", 64'(in_ready), 64'h1);
        chk("bp_count_after_pop", 64'(fifo_count), 64'd3);
        for (int i = 0; i < 3; i++) begin
            chk("bp_no_bubble", 64'(out_valid), 64'h1);
            @(posedge clk);
            #1;
        end
        drain();

        n0 = nout;
        for (int i = 0; i < 20; i++) begin
            send(32'h1, 5'(i), 3'b010, 32'h1 << i, 1'b0);
            in_valid = 1'b1;
            chk("ss_count", 64'(fifo_count), 64'h1);
            if (i > 0) chk("ss_out_valid", 64'(out_valid), 64'h1);
        end
        in_valid = 1'b0;
        drain();
        chk("ss_results", 64'(nout - n0), 64'd20);

        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(32'hA0 + 32'(i), 5'd0, 3'b000, 32'hA0 + 32'(i), 1'b0);
        chk("pre_rst_count", 64'(fifo_count), 64'd3);
        chk("pre_rst_out_valid", 64'(out_valid), 64'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid), 64'h0);
        chk("arst_count", 64'(fifo_count), 64'h0);
        chk("arst_rot_a", 64'(rot_a), 64'h0);
        chk("arst_in_ready", 64'(in_ready), 64'h1);
        sb.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        n0 = nout;
        send(32'hCAFE_F00D, 5'd16, 3'b001, 32'hF00D_CAFE, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_results", 64'(nout - n0), 64'd1);
        chk("post_rst_sb", 64'(sb.size()), 64'h0);
        chk("post_rst_out_valid", 64'(out_valid), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/shift_issue_unit.md
# shift_issue_unit

Upstream issue stage for the 32-bit combinational rotator. Accepts shift requests over a valid/ready handshake and buffers them in a small FIFO. Drives the rotator from the FIFO head, then masks and sign-fills the rotated word to build logical and arithmetic shifts. Registers the final result toward the consumer with its own valid/ready handshake.

## Interface
- DEPTH, 4, request FIFO entries; power of two, ≥2
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  request present
- in_ready  output  1  unit can accept; equals (count != DEPTH)
- in_data  input  32  operand
- in_amt  input  5  shift amount 0–31
- in_op  input  3  000 ROL, 001 ROR, 010 SLL, 011 SRL, 111 SRA, others reserved
- rot_a  output  32  rotator operand
- rot_shift  output  5  rotator amount
- rot_l  output  1  rotator direction: 1 left, 0 right
- rot_b  input  32  rotator result, combinational from rot_a/rot_shift/rot_l
- out_valid  output  1  result register holds a result
- out_ready  input  1  consumer accepts
- out_data  output  32  shifted result
- out_err  output  1  result came from a reserved op
- fifo_count  output  $clog2(DEPTH)+1  occupied FIFO entries

## Operation
- Push: in_valid && in_ready stores {in_data, in_amt, in_op} at the write pointer. Pointers wrap modulo DEPTH.
- Head valid when count > 0. pop = head_valid && (!out_valid || out_ready).
- Rotator drive:
  - When head is valid: rot_a = head data, rot_shift = head amt.
  - rot_l = 1 for ROL/SLL; 0 for ROR/SRL/SRA.
  - When FIFO is empty, all three rot_* outputs are 0.
- Result formation on pop, with n = amt:
  - ROL/ROR: rot_b.
  - SLL: rot_b & (32'hFFFFFFFF << n).
  - SRL: rot_b & (32'hFFFFFFFF >> n).
  - SRA: SRL value | (data[31] ? ~(32'hFFFFFFFF >> n) : 0).
  - Reserved op: head data unmodified, with out_err=1. Otherwise out_err=0.
- n=0: every op returns data unchanged.
- On pop, result and err load into the output register and out_valid is set.
- If there is no pop and out_ready && out_valid, out_valid clears. out_data holds its last value.
- Simultaneous push and pop: count is unchanged and both pointers advance. Not possible when full, because in_ready=0.
- Push into an empty FIFO is not bypassed; the entry must be registered first.

## Timing
- Reset, asynchronous and immediate:
  - count=0, pointers=0.
  - out_valid=0, out_data=0, out_err=0.
  - rot_*=0, in_ready=1.
  - FIFO storage is not reset.
- Reset mid-operation discards all queued and output-held requests. The first post-reset push is handled normally.
- Latency: request accepted at edge ending cycle t is the head in t+1, popped at end of t+1, and out_valid=1 in t+2.
- Throughput is 1 result/cycle with out_ready held high.
- Capacity under stall: DEPTH requests in the FIFO plus 1 in the output register.
- in_ready and fifo_count depend only on registered state (no in_valid→in_ready path).
- out_valid/out_data remain stable while out_valid && !out_ready.

## Test plan
- Rotates: ROL 0x80000001 amt 1 → 0x00000003; ROR 0x00000001 amt 4 → 0x10000000. out_valid two cycles after the accepting edge.
- Logical/arithmetic shifts:
  - SLL 0xFFFFFFFF amt 8 → 0xFFFFFF00.
  - SRL 0x80000000 amt 31 → 0x00000001.
  - SRA 0x80000000 amt 31 → 0xFFFFFFFF.
  - SRA 0x40000000 amt 4 → 0x04000000.
- Backpressure, out_ready=0 with continuous pushes of 1,2,3,…:
  - Exactly DEPTH+1 (5) requests are accepted, then in_ready=0 and fifo_count=4.
  - Raise out_ready: outputs 1..5 in order, one per cycle.
  - in_ready returns 1 the cycle after the first pop.
- Concurrent push/pop at steady state (out_ready=1, in_valid=1 for 20 cycles): fifo_count constant at 1, 20 in-order results, no bubbles.
- Reserved op 100 on 0x12345678 amt 7 → out_data=0x12345678, out_err=1. Next valid op → out_err=0. amt 0 with every op → data unchanged.
- Reset asserted with 3 queued and out_valid=1:
  - out_valid=0, fifo_count=0, rot_a=0 immediately, without a clock edge.
  - After deassert, a single push produces exactly one result.
